// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU scheduler: opcodes, flag bit
// positions and the scheduler FSM state type.
package alu_pkg;

  // Opcodes, fully decoded across the 4-bit space
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_LT  = 4'hE;
  localparam logic [3:0] OP_EQ  = 4'hF;

  // Bit positions inside rsp_flags = {S, Z, P, AC}
  localparam int FLG_S  = 3;
  localparam int FLG_Z  = 2;
  localparam int FLG_P  = 1;
  localparam int FLG_AC = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU. Carry is bit 8 of the sum for ADD, the unsigned
// borrow (a < b) for SUB and zero for every other opcode.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       carry
);

  logic [8:0] sum9;

  // Decode the opcode into a result and carry
  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    sum9   = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        result = sum9[7:0];
        carry  = sum9[8];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_MUL:  result = a * b;
      OP_DIV:  result = (b == 8'h00) ? 8'h00 : (a / b);
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = {a[6:0], 1'b0};
      OP_SHR:  result = {1'b0, a[7:1]};
      OP_ROL:  result = {a[6:0], a[7]};
      OP_ROR:  result = {a[0], a[7:1]};
      OP_INC:  result = a + 8'h01;
      OP_DEC:  result = a - 8'h01;
      OP_LT:   result = {7'b0, (a < b)};
      OP_EQ:   result = {7'b0, (a == b)};
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward (mod NUM_REQ) and
// returns the first active request as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int  idx;
  logic found;

  // Walk the requesters starting at the pointer and take the first one
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one alu_8bit among NUM_REQ requesters, one operation at a time.
// IDLE grants round-robin, EXEC runs the latched operands through the ALU
// and registers the response, RESP holds it until rsp_ready.
// Optional macro ALU_SHARE_FLAGS_EN enables the registered {S,Z,P,AC}
// flags; without it rsp_flags is tied to zero.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 rsp_carry,
  output logic [3:0]           rsp_flags
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [3:0]         op_q, op_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [7:0]         rsp_result_q, rsp_result_d;
  logic               rsp_carry_q, rsp_carry_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [7:0]         alu_result;
  logic               alu_carry;
  logic [7:0]         res_fin;
  logic               carry_fin;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  alu_8bit u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Divide by zero never reaches the response: force result and carry to 0
  always_comb begin
    res_fin   = alu_result;
    carry_fin = alu_carry;
    if (op_q == OP_DIV && b_q == 8'h00) begin
      res_fin   = 8'h00;
      carry_fin = 1'b0;
    end
  end

  // Next-state, operand latching and handshake outputs for the scheduler
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|grant) begin
          op_d    = req_op[4*grant_idx +: 4];
          a_d     = req_a[8*grant_idx +: 8];
          b_d     = req_b[8*grant_idx +: 8];
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = res_fin;
        rsp_carry_d  = carry_fin;
        rsp_id_d     = id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state, latched request and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;

`ifdef ALU_SHARE_FLAGS_EN
  logic [3:0] rsp_flags_q, rsp_flags_d;
  logic [4:0] nib_sum;
  logic       half_carry;

  // Status flags derived from the final result, captured alongside it in EXEC
  always_comb begin
    rsp_flags_d = rsp_flags_q;
    nib_sum     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};
    half_carry  = 1'b0;
    if (op_q == OP_ADD)      half_carry = nib_sum[4];
    else if (op_q == OP_SUB) half_carry = (a_q[3:0] < b_q[3:0]);
    if (state_q == ST_EXEC) begin
      rsp_flags_d[FLG_S]  = res_fin[7];
      rsp_flags_d[FLG_Z]  = (res_fin == 8'h00);
      rsp_flags_d[FLG_P]  = ~^res_fin;
      rsp_flags_d[FLG_AC] = half_carry;
    end
  end

  // Flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_flags_q <= '0;
    else        rsp_flags_q <= rsp_flags_d;
  end

  assign rsp_flags = rsp_flags_q;
`else
  assign rsp_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: table of single-requester operations plus
// hand-written sequences for round-robin, backpressure and mid-op reset.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef ALU_SHARE_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_op;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_result;
  logic                 rsp_carry;
  logic [3:0]           rsp_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         req;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
  } vec_t;

  vec_t vecs[12];

  alu_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_flags  (rsp_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] expFlags(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] res);
    logic [3:0] f;
    f[3] = res[7];
    f[2] = (res == 8'h00);
    f[1] = ~^res;
    if (op == OP_ADD)      f[0] = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
    else if (op == OP_SUB) f[0] = (a[3:0] < b[3:0]);
    else                   f[0] = 1'b0;
    return f & FLAG_MASK;
  endfunction

  task automatic setReq(input int r, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    req_op[4*r +: 4] = op;
    req_a[8*r +: 8]  = a;
    req_b[8*r +: 8]  = b;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One request from a single requester, then check latency and response
  task automatic applyStimulus(input vec_t v);
    int cyc;
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    onehot[v.req] = 1'b1;
    @(posedge clk); #1;
    setReq(v.req, v.op, v.a, v.b);
    req_valid[v.req] = 1'b1;
    #1;
    cyc = 0;
    while (req_ready[v.req] !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput($sformatf("req_ready_v%0d", v.req), 32'(req_ready), 32'(onehot));
    @(posedge clk); #1;
    req_valid[v.req] = 1'b0;
    checkOutput("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("rsp_valid_lat", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_result", 32'(rsp_result), 32'(v.res));
    checkOutput("rsp_carry", 32'(rsp_carry), 32'(v.carry));
    checkOutput("rsp_id", 32'(rsp_id), 32'(v.req));
    checkOutput("rsp_flags", 32'(rsp_flags), 32'(expFlags(v.op, v.a, v.b, v.res)));
  endtask

  initial begin
    int ids[6];
    int times[6];
    int got;
    int cyc;

    vecs[0]  = '{0,  OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[1]  = '{2,  OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1};
    vecs[2]  = '{2,  OP_DIV, 8'h09, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1,  OP_MUL, 8'h10, 8'h11, 8'h10, 1'b0};
    vecs[4]  = '{3,  OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[5]  = '{0,  OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[6]  = '{1,  OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[7]  = '{3,  OP_DIV, 8'h64, 8'h07, 8'h0E, 1'b0};
    vecs[8]  = '{0,  OP_EQ,  8'h33, 8'h33, 8'h01, 1'b0};
    vecs[9]  = '{2,  OP_LT,  8'h03, 8'h05, 8'h01, 1'b0};
    vecs[10] = '{1,  OP_SUB, 8'h80, 8'h80, 8'h00, 1'b0};
    vecs[11] = '{3,  OP_ROL, 8'h81, 8'h00, 8'h03, 1'b0};

    doReset();
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("reset_rsp_carry", 32'(rsp_carry), 32'd0);
    checkOutput("reset_rsp_flags", 32'(rsp_flags), 32'd0);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Round robin: all four requesters valid with ADD 1+1
    doReset();
    for (int r = 0; r < NUM_REQ; r++) setReq(r, OP_ADD, 8'h01, 8'h01);
    req_valid = 4'b1111;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin
        ids[got]   = int'(rsp_id);
        times[got] = cyc;
        checkOutput("rr_result", 32'(rsp_result), 32'h02);
        got++;
      end
    end
    req_valid = '0;
    checkOutput("rr_count", 32'(got), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < got) begin
        checkOutput($sformatf("rr_id%0d", k), 32'(ids[k]), 32'(k % NUM_REQ));
        if (k > 0) checkOutput($sformatf("rr_gap%0d", k), 32'(times[k] - times[k-1]), 32'd3);
      end
    end

    // Backpressure: response held for 10 cycles, req1 waiting meanwhile
    doReset();
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    setReq(0, OP_ADD, 8'h03, 8'h04);
    setReq(1, OP_ADD, 8'h05, 8'h06);
    req_valid = 4'b0001;
    #1;
    checkOutput("bp_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    checkOutput("bp_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_result", 32'(rsp_result), 32'h07);
      checkOutput("bp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_regrant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    checkOutput("bp2_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp2_result", 32'(rsp_result), 32'h0B);
    checkOutput("bp2_id", 32'(rsp_id), 32'd1);

    // Reset asserted while EXEC: outputs clear at once, pointer back to 0
    @(posedge clk); #1;
    setReq(0, OP_ADD, 8'h01, 8'h02);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_result", 32'(rsp_result), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_carry", 32'(rsp_carry), 32'd0);
    checkOutput("rst_flags", 32'(rsp_flags), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    setReq(1, OP_EQ, 8'h33, 8'h33);
    setReq(3, OP_ADD, 8'h01, 8'h01);
    req_valid = 4'b1010;
    #1;
    checkOutput("post_rst_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    checkOutput("post_rst_valid", 32'(rsp_valid), 32'd1);
    checkOutput("post_rst_result", 32'(rsp_result), 32'h01);
    checkOutput("post_rst_id", 32'(rsp_id), 32'd1);
    checkOutput("post_rst_carry", 32'(rsp_carry), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Round-robin scheduler that shares one `alu_8bit` datapath among `NUM_REQ` requesters. Each requester presents an opcode and two operands on a valid/ready channel. The block grants one request at a time, latches its operands, and executes the operation. It then returns the registered result, carry/borrow, optional status flags and the requester ID on a single valid/ready response channel. It sits between the instruction-decode clients and the shared ALU, and is the only block that drives the ALU inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req_valid` input, `NUM_REQ` bits: per-requester request valid.
- `req_ready` output, `NUM_REQ` bits: per-requester accept; one-hot or zero.
- `req_op` input, `4*NUM_REQ` bits: 4-bit opcode per requester; slice i = bits [4i+3:4i].
- `req_a` input, `8*NUM_REQ` bits: operand A per requester.
- `req_b` input, `8*NUM_REQ` bits: operand B per requester.
- `rsp_valid` output, 1 bit: response valid.
- `rsp_ready` input, 1 bit: response accept.
- `rsp_id` output, `ID_W` bits: index of the requester served.
- `rsp_result` output, 8 bits: ALU result.
- `rsp_carry` output, 1 bit: carry for ADD, borrow for SUB, 0 for all other ops.
- `rsp_flags` output, 4 bits: {S, Z, P, AC}.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready[g]` = 1 only for the winner g, combinational from `req_valid` and the RR pointer.
  - Winner = first i with `req_valid[i]`, searching pointer, pointer+1, … mod NUM_REQ.
  - On handshake: latch op/a/b/id, set pointer = g+1 mod NUM_REQ, go to EXEC.
  - No valid request: stay in IDLE, `req_ready` = 0.
- EXEC:
  - ALU inputs driven from the latched registers; `req_ready` = 0.
  - At the clock edge, capture result/carry/flags into the `rsp_*` registers; go to RESP.
- RESP:
  - `rsp_valid` = 1; all `rsp_*` outputs held stable until `rsp_valid` & `rsp_ready`, then go to IDLE.
  - `req_ready` = 0 throughout.
- Arithmetic rules:
  - Carry for ADD = bit 8 of the 9-bit sum.
  - Borrow for SUB = (a < b), unsigned.
  - MUL keeps the low 8 bits.
  - DIV with b == 0 forces result 8'h00 and carry 0; the block overrides the ALU output.
- ALU output is never X toward the response: opcodes are 4 bits and fully decoded, and DIV by zero is overridden.
- Requesters must hold op/a/b stable while `req_valid` is high and not yet accepted.
- Requester ordering:
  - Dropping `req_valid` before acceptance is allowed.
  - A requester with a pending response is not blocked from requesting again.
  - Responses stay in grant order because the block handles one request at a time.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_carry` = 0, `rsp_flags` = 0.
  - State = IDLE, pointer = 0.
- Latency: request handshake at edge N gives `rsp_valid` high in the cycle after edge N+1, i.e. 2 cycles.
- Peak throughput: one operation per 3 cycles when `rsp_ready` is held high.
- Backpressure: `rsp_ready` low holds RESP indefinitely; no new grant is issued.
- All requesters valid continuously: grants rotate 0,1,2,3,0,… with no starvation.
- `rst_n` asserted mid-operation: FSM returns to IDLE immediately and any in-flight request/response is discarded; requesters re-issue.
- `rst_n` is released synchronously by the upstream reset synchronizer.

## Configuration
- Macro: `ALU_SHARE_FLAGS_EN`.
- Defined: `rsp_flags` registered in EXEC:
  - S = result[7]
  - Z = (result == 0)
  - P = even parity of result
  - AC = carry out of bit 3 for ADD/SUB, else 0.
- Undefined:
  - `rsp_flags` is tied to 4'b0000 and no flag logic is synthesised.
  - The port is still present.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `OP_ADD`=4'h0 … `OP_EQ`=4'hF.
  - Flag bit indices `FLG_S`=3, `FLG_Z`=2, `FLG_P`=1, `FLG_AC`=0.
  - FSM state typedef.
- Sub-module `rr_arbiter`:
  - Parameterised by `NUM_REQ`.
  - Inputs: requests, pointer.
  - Outputs: one-hot grant and encoded index.
- Instances in this block: `alu_8bit` once and `rr_arbiter` once.

## Test plan
- Req0 ADD a=8'hF0, b=8'h20, `rsp_ready`=1 → `rsp_valid` 2 cycles after handshake; result=8'h10, carry=1, id=0; flags {S0,Z0,P0,AC0} with `ALU_SHARE_FLAGS_EN`.
- Req2 SUB a=8'h05, b=8'h07 → result=8'hFE, carry=1; DIV a=8'h09, b=0 → result=8'h00, carry=0.
- All 4 requesters held valid with ops ADD 1+1 → rsp_id sequence 0,1,2,3,0,1; one response every 3 cycles.
- `rsp_ready` low 10 cycles during RESP → outputs stable, `req_ready`=0 throughout; release → next grant in the following IDLE cycle.
- Assert `rst_n` during EXEC → all outputs 0 asynchronously; after release, req1 EQ a=b=8'h33 → result=8'h01, id=1, pointer started from 0.
